// File: rtl/fifo_depth_base.sv
// Parametrised-depth elastic FIFO between a PipeIn and a PipeOut server.
// Adds occupancy count, almost-full flag, synchronous clear and optional pipelined full-enqueue.
module fifo_depth_base #(
  parameter int width       = 999999,
  parameter int depth       = 4,
  parameter int afull_level = depth - 1,
  parameter bit pipelined   = 1'b0
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         in_enq__ENA,
  input  logic [width-1:0]             in_enq_v,
  output logic                         in_enq__RDY,
  input  logic                         out_deq__ENA,
  output logic                         out_deq__RDY,
  output logic [width-1:0]             out_first,
  output logic                         out_first__RDY,
  input  logic                         clear__ENA,
  output logic                         clear__RDY,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         afull
);

  localparam int pw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);

  generate
    if (width < 1 || depth < 2 || afull_level < 1 || afull_level > depth) begin : g_bad_params
      $error("fifo_depth_base: illegal parameter combination");
    end
  endgenerate

  // Storage is deliberately left out of reset; the pointers alone define validity.
  logic [width-1:0] storage_mem [depth];

  logic [pw-1:0] rd_ptr_reg, rd_ptr_next;
  logic [pw-1:0] wr_ptr_reg, wr_ptr_next;
  logic [cw-1:0] count_reg, count_next;

  logic empty;
  logic full;
  logic enq_fire;
  logic deq_fire;
  logic wr_en;

  // Explicit wrap so non-power-of-two depths behave like any other.
  function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
    return (p == pw'(depth - 1)) ? '0 : p + pw'(1);
  endfunction

  assign empty = (count_reg == '0);
  assign full  = (count_reg == cw'(depth));

  generate
    if (pipelined) begin : g_pipe_rdy
      // A dequeue in the same cycle frees the slot the enqueue will land in.
      assign in_enq__RDY = !full || out_deq__ENA;
    end else begin : g_reg_rdy
      assign in_enq__RDY = !full;
    end
  endgenerate

  assign enq_fire = in_enq__ENA && in_enq__RDY;
  assign deq_fire = out_deq__ENA && !empty;
  assign wr_en    = enq_fire && !clear__ENA;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      storage_mem[wr_ptr_reg] <= in_enq_v;
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (clear__ENA) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (enq_fire) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (deq_fire) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      if (enq_fire && !deq_fire) begin
        count_next = count_reg + cw'(1);
      end else if (deq_fire && !enq_fire) begin
        count_next = count_reg - cw'(1);
      end
    end
  end

  always_comb begin
    out_deq__RDY   = !empty;
    out_first__RDY = !empty;
    out_first      = empty ? '0 : storage_mem[rd_ptr_reg];
    clear__RDY     = 1'b1;
    count          = count_reg;
    afull          = (count_reg >= cw'(afull_level));
  end

  // Strobes raised while their ready is low are protocol errors.
  a_enq_proto: assert property (@(posedge CLK) disable iff (!nRST) in_enq__ENA |-> in_enq__RDY);
  a_deq_proto: assert property (@(posedge CLK) disable iff (!nRST) out_deq__ENA |-> out_deq__RDY);
  a_count_max: assert property (@(posedge CLK) disable iff (!nRST) count_reg <= cw'(depth));

endmodule

// File: tb/tb_fifo_depth_base.sv
// Bench for fifo_depth_base: three instances (d4/p0, d3/p0, d4/p1), vector table,
// hand-written corner sequences and a queue-based random reference model.
module tb_fifo_depth_base;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  logic       enq_ena [3];
  logic [7:0] enq_v   [3];
  logic       deq_ena [3];
  logic       clr     [3];
  logic       enq_rdy [3];
  logic       deq_rdy [3];
  logic       frst_rdy[3];
  logic       clr_rdy [3];
  logic       afull_o [3];
  logic [7:0] first_o [3];
  logic [2:0] cnt_o   [3];
  logic [1:0] cnt_d3;
  assign cnt_o[1] = {1'b0, cnt_d3};

  fifo_depth_base #(.width(8), .depth(4), .afull_level(3), .pipelined(1'b0)) u_d4p0 (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(enq_ena[0]), .in_enq_v(enq_v[0]), .in_enq__RDY(enq_rdy[0]),
    .out_deq__ENA(deq_ena[0]), .out_deq__RDY(deq_rdy[0]),
    .out_first(first_o[0]), .out_first__RDY(frst_rdy[0]),
    .clear__ENA(clr[0]), .clear__RDY(clr_rdy[0]),
    .count(cnt_o[0]), .afull(afull_o[0])
  );

  fifo_depth_base #(.width(8), .depth(3), .afull_level(2), .pipelined(1'b0)) u_d3p0 (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(enq_ena[1]), .in_enq_v(enq_v[1]), .in_enq__RDY(enq_rdy[1]),
    .out_deq__ENA(deq_ena[1]), .out_deq__RDY(deq_rdy[1]),
    .out_first(first_o[1]), .out_first__RDY(frst_rdy[1]),
    .clear__ENA(clr[1]), .clear__RDY(clr_rdy[1]),
    .count(cnt_d3), .afull(afull_o[1])
  );

  fifo_depth_base #(.width(8), .depth(4), .afull_level(3), .pipelined(1'b1)) u_d4p1 (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(enq_ena[2]), .in_enq_v(enq_v[2]), .in_enq__RDY(enq_rdy[2]),
    .out_deq__ENA(deq_ena[2]), .out_deq__RDY(deq_rdy[2]),
    .out_first(first_o[2]), .out_first__RDY(frst_rdy[2]),
    .clear__ENA(clr[2]), .clear__RDY(clr_rdy[2]),
    .count(cnt_o[2]), .afull(afull_o[2])
  );

  int dep[3] = '{4, 3, 4};
  int afl[3] = '{3, 2, 3};
  bit pip[3] = '{1'b0, 1'b0, 1'b1};

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         inst;
    logic       enq;
    logic [7:0] v;
    logic       deq;
    logic       clr;
    logic       rdy_now;
    logic       deq_rdy;
    logic [7:0] first;
    logic [2:0] cnt;
    logic       afull;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int inst, input logic enq, input logic [7:0] v, input logic deq,
                     input logic c, input logic rdy_now, input logic drdy, input logic [7:0] f,
                     input logic [2:0] n, input logic af);
    vec_t t;
    t.inst = inst; t.enq = enq; t.v = v; t.deq = deq; t.clr = c;
    t.rdy_now = rdy_now; t.deq_rdy = drdy; t.first = f; t.cnt = n; t.afull = af;
    vecs.push_back(t);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      enq_ena[i] = 1'b0; enq_v[i] = 8'h00; deq_ena[i] = 1'b0; clr[i] = 1'b0;
    end
  endtask

  task automatic drive(input int i, input logic e, input logic [7:0] v, input logic d, input logic c);
    enq_ena[i] = e; enq_v[i] = v; deq_ena[i] = d; clr[i] = c;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  task automatic chk_state(input string tag, input int i, input logic drdy, input logic [7:0] f,
                           input logic [2:0] n, input logic af);
    chk($sformatf("%s[%0d] deq_rdy", tag, i), deq_rdy[i], drdy);
    chk($sformatf("%s[%0d] first", tag, i), first_o[i], f);
    chk($sformatf("%s[%0d] count", tag, i), cnt_o[i], n);
    chk($sformatf("%s[%0d] afull", tag, i), afull_o[i], af);
  endtask

  logic [7:0] mq[$];

  task automatic random_phase(input int i, input int cycles);
    logic exp_rdy;
    int   sz;
    drive(i, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    mq.delete();
    for (int c = 0; c < cycles; c++) begin
      bit fill_bias = ((c % 80) < 40);
      sz = mq.size();
      clr[i]     = ($urandom_range(0, 24) == 0);
      deq_ena[i] = (sz > 0) && ($urandom_range(0, 9) < (fill_bias ? 3 : 8));
      exp_rdy    = (sz < dep[i]) || (pip[i] && deq_ena[i]);
      enq_ena[i] = exp_rdy && ($urandom_range(0, 9) < (fill_bias ? 8 : 3));
      enq_v[i]   = 8'($urandom);
      #1;
      chk($sformatf("rnd%0d[%0d] enq_rdy", c, i), enq_rdy[i], exp_rdy);
      chk($sformatf("rnd%0d[%0d] first_rdy", c, i), frst_rdy[i], sz > 0);
      chk_state($sformatf("rnd%0d", c), i, sz > 0, (sz > 0) ? mq[0] : 8'h00, 3'(sz), sz >= afl[i]);
      if (clr[i]) begin
        mq.delete();
      end else begin
        if (deq_ena[i]) void'(mq.pop_front());
        if (enq_ena[i]) mq.push_back(enq_v[i]);
      end
      tick();
    end
  endtask

  initial begin
    int nxt;
    idle_inputs();

    // Reset asserted between edges: outputs must respond without a clock.
    #2 nRST = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst[%0d] enq_rdy", i), enq_rdy[i], 1'b1);
      chk($sformatf("rst[%0d] clr_rdy", i), clr_rdy[i], 1'b1);
      chk($sformatf("rst[%0d] first_rdy", i), frst_rdy[i], 1'b0);
      chk_state("rst", i, 1'b0, 8'h00, 3'd0, 1'b0);
    end
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Fill/drain, depth 4, registered ready.
    add(0, 1, 8'h11, 0, 0, 1, 1, 8'h11, 3'd1, 0);
    add(0, 1, 8'h22, 0, 0, 1, 1, 8'h11, 3'd2, 0);
    add(0, 1, 8'h33, 0, 0, 1, 1, 8'h11, 3'd3, 1);
    add(0, 1, 8'h44, 0, 0, 1, 1, 8'h11, 3'd4, 1);
    add(0, 0, 8'h00, 1, 0, 0, 1, 8'h22, 3'd3, 1);
    add(0, 0, 8'h00, 1, 0, 1, 1, 8'h33, 3'd2, 0);
    add(0, 0, 8'h00, 1, 0, 1, 1, 8'h44, 3'd1, 0);
    add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 3'd0, 0);
    // Full + dequeue with registered ready: no enqueue room that cycle.
    add(0, 1, 8'hAA, 0, 0, 1, 1, 8'hAA, 3'd1, 0);
    add(0, 1, 8'hBB, 0, 0, 1, 1, 8'hAA, 3'd2, 0);
    add(0, 1, 8'hCC, 0, 0, 1, 1, 8'hAA, 3'd3, 1);
    add(0, 1, 8'hDD, 0, 0, 1, 1, 8'hAA, 3'd4, 1);
    add(0, 0, 8'h00, 1, 0, 0, 1, 8'hBB, 3'd3, 1);
    add(0, 0, 8'h00, 1, 0, 1, 1, 8'hCC, 3'd2, 0);
    add(0, 0, 8'h00, 1, 0, 1, 1, 8'hDD, 3'd1, 0);
    add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 3'd0, 0);
    // Full + simultaneous enq/deq with pipelined ready.
    add(2, 1, 8'hAA, 0, 0, 1, 1, 8'hAA, 3'd1, 0);
    add(2, 1, 8'hBB, 0, 0, 1, 1, 8'hAA, 3'd2, 0);
    add(2, 1, 8'hCC, 0, 0, 1, 1, 8'hAA, 3'd3, 1);
    add(2, 1, 8'hDD, 0, 0, 1, 1, 8'hAA, 3'd4, 1);
    add(2, 0, 8'h00, 0, 0, 0, 1, 8'hAA, 3'd4, 1);
    add(2, 1, 8'hEE, 1, 0, 1, 1, 8'hBB, 3'd4, 1);
    add(2, 0, 8'h00, 1, 0, 1, 1, 8'hCC, 3'd3, 1);
    add(2, 0, 8'h00, 1, 0, 1, 1, 8'hDD, 3'd2, 0);
    add(2, 0, 8'h00, 1, 0, 1, 1, 8'hEE, 3'd1, 0);
    add(2, 0, 8'h00, 1, 0, 1, 0, 8'h00, 3'd0, 0);
    // Clear wins over concurrent enq and deq.
    add(0, 1, 8'h01, 0, 0, 1, 1, 8'h01, 3'd1, 0);
    add(0, 1, 8'h02, 0, 0, 1, 1, 8'h01, 3'd2, 0);
    add(0, 1, 8'h55, 1, 1, 1, 0, 8'h00, 3'd0, 0);
    add(0, 1, 8'h66, 0, 0, 1, 1, 8'h66, 3'd1, 0);
    add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 3'd0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].inst, vecs[k].enq, vecs[k].v, vecs[k].deq, vecs[k].clr);
      #1;
      chk($sformatf("vec%0d[%0d] enq_rdy", k, vecs[k].inst), enq_rdy[vecs[k].inst], vecs[k].rdy_now);
      tick();
      chk_state($sformatf("vec%0d", k), vecs[k].inst, vecs[k].deq_rdy, vecs[k].first,
                vecs[k].cnt, vecs[k].afull);
    end

    // Wrap-around on depth 3: values 1..10 must leave in order with occupancy 1..2.
    nxt = 1;
    drive(1, 1'b1, 8'd1, 1'b0, 1'b0); tick();
    drive(1, 1'b1, 8'd2, 1'b0, 1'b0); tick();
    for (int v = 3; v <= 10; v++) begin
      drive(1, 1'b1, 8'(v), 1'b1, 1'b0);
      #1;
      chk($sformatf("wrap v%0d first", v), first_o[1], 8'(nxt));
      nxt++;
      tick();
      chk($sformatf("wrap v%0d count", v), cnt_o[1], 3'd2);
      chk($sformatf("wrap v%0d afull", v), afull_o[1], 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      chk($sformatf("wrap tail%0d first", k), first_o[1], 8'(nxt));
      nxt++;
      tick();
    end
    chk_state("wrap end", 1, 1'b0, 8'h00, 3'd0, 1'b0);

    // Reset between edges while holding 3 words, then reuse.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 8'(8'hA0 + k), 1'b0, 1'b0);
      tick();
    end
    chk("pre_rst count", cnt_o[0], 3'd3);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst enq_rdy", enq_rdy[0], 1'b1);
    chk_state("mid_rst", 0, 1'b0, 8'h00, 3'd0, 1'b0);
    #2 nRST = 1'b1;
    drive(0, 1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    chk_state("post_rst", 0, 1'b1, 8'h77, 3'd1, 1'b0);
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk_state("post_rst drain", 0, 1'b0, 8'h00, 3'd0, 1'b0);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 3; i++) begin
      random_phase(i, 400);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_depth_base.md
# fifo_depth_base

Parametrised-depth successor to the single-entry pipe FIFO. It buffers up to `depth` words of `width` bits between a PipeIn server and a PipeOut server. Over the one-entry version it adds an occupancy count, an almost-full flag, a synchronous clear method, and an optional pipelined mode that accepts an enqueue into a full FIFO when a dequeue fires in the same cycle. It is the default elastic buffer between method-connected modules wherever more than one entry of slack is needed.

## Interface
- `width`, 999999: data word width in bits; must be ≥1.
- `depth`, 4: number of entries; any integer ≥2, not required to be a power of two.
- `afull_level`, depth-1: `afull` asserts when count ≥ this value; range 1..depth.
- `pipelined`, 0: 1 lets `in.enq__RDY` also assert when full and `out.deq__ENA` is high (combinational path deq__ENA→enq__RDY); 0 keeps enq__RDY registered-only.
- CLK  input  1  clock; all state updates on its rising edge.
- nRST  input  1  reset, asynchronous, active-low; asserting it clears the state immediately, independent of CLK.
- in.enq__ENA  input  1  enqueue strobe; honoured only when in.enq__RDY is high.
- in.enq$v  input  width  enqueue data.
- in.enq__RDY  output  1  enqueue permitted.
- out.deq__ENA  input  1  dequeue strobe; honoured only when out.deq__RDY is high.
- out.deq__RDY  output  1  dequeue permitted (not empty).
- out.first  output  width  head-of-queue word; 0 when empty.
- out.first__RDY  output  1  out.first valid (not empty).
- clear__ENA  input  1  synchronous flush of all entries.
- clear__RDY  output  1  constant 1.
- count  output  $clog2(depth+1)  current occupancy.
- afull  output  1  count ≥ afull_level.

## Operation
- State: storage array [depth] of width bits, not reset; rd_ptr and wr_ptr, each $clog2(depth) bits; count register.
- Pointers wrap explicitly: ptr == depth-1 → 0. No reliance on power-of-two overflow.
- empty = (count == 0); full = (count == depth).
- in.enq__RDY = !full, or when pipelined=1, !full || out.deq__ENA.
- out.deq__RDY = out.first__RDY = !empty.
- out.first = empty ? 0 : storage[rd_ptr].
- enq = in.enq__ENA && in.enq__RDY: writes in.enq$v to storage[wr_ptr] and advances wr_ptr.
- deq = out.deq__ENA && out.deq__RDY: advances rd_ptr.
- count update: enq only → +1; deq only → −1; both or neither → unchanged.
- Simultaneous enq and deq when full (pipelined=1 only): the write lands in the slot being freed (wr_ptr == rd_ptr); count stays depth. Ordering is preserved.
- Simultaneous enq and deq when empty: deq is not allowed because deq__RDY is low. Enqueue proceeds. No bypass, so data never passes through in zero cycles.
- clear__ENA takes priority over enq and deq in the same cycle: rd_ptr, wr_ptr and count go to 0; any concurrent enq is dropped.
- Reset (nRST low): rd_ptr, wr_ptr and count go to 0 asynchronously. Resulting output values: in.enq__RDY=1, out.deq__RDY=0, out.first__RDY=0, out.first=0, count=0, afull=0, clear__RDY=1. Reset mid-transfer discards all contents. The first enqueue is accepted on the first rising edge after nRST deasserts.
- An ENA with its RDY low is ignored: no state change. A checker assertion flags it as a protocol error.

## Timing
- Enqueue→visible latency is 1 cycle: data enqueued at edge k appears on out.first with first__RDY high after edge k when the FIFO was empty.
- Throughput is 1 word/cycle sustained, including in the full state when pipelined=1. With pipelined=0 there is one bubble on refill from full: enq__RDY rises the cycle after the deq.
- count and afull are registered-derived: they reflect the state after the last edge and have no combinational path from ENA inputs.
- The only combinational input→output path is out.deq__ENA→in.enq__RDY, and it exists only when pipelined=1.

## Test plan
- Reset/idle: pulse nRST low mid-cycle, with no clock edge → outputs immediately read enq__RDY=1, deq__RDY=0, first=0, count=0, afull=0.
- Fill/drain, depth=4, width=8, pipelined=0: enqueue 0x11, 0x22, 0x33, 0x44 on consecutive cycles → count goes 1,2,3,4; afull high at count 3; enq__RDY low at 4. Dequeue 4 times → first shows 0x11, 0x22, 0x33, 0x44 in order, then deq__RDY=0 and first=0.
- Wrap-around, depth=3 (non-power-of-two): 10 interleaved enq/deq of values 1..10 with occupancy held at 1–2 → output order 1..10, pointers wrap 2→0, count never exceeds 3.
- Full-simultaneous: depth=4 full with A..D, pipelined=1, assert enq (0xEE) and deq together → enq__RDY high that cycle, count stays 4, dequeue order A,B,C,D,0xEE. Same stimulus with pipelined=0 → enq__RDY low, 0xEE not accepted, count drops to 3.
- Clear priority: FIFO holding 2 words, assert clear__ENA together with enq(0x55) and deq → next cycle count=0, deq__RDY=0; a subsequent dequeue after one enq(0x66) yields 0x66.
- Reset mid-operation: FIFO holding 3 words, drop nRST between edges → count=0 and deq__RDY=0 immediately; after release, enq 0x77 then deq → first=0x77, no stale data.
